// File: rtl/cpu_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_trace_buffer
// Brief    : Retirement-trace capture buffer with stop-PC freeze and a
//            show-ahead valid/ready drain port.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_trace_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int MODE  = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     trc_valid,
    input  logic [XLEN-1:0]          trc_pc,
    input  logic [XLEN-1:0]          trc_iaddr,
    input  logic [XLEN-1:0]          trc_wdata,
    input  logic                     stop_en,
    input  logic [XLEN-1:0]          stop_pc,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [XLEN-1:0]          rd_pc,
    output logic [XLEN-1:0]          rd_iaddr,
    output logic [XLEN-1:0]          rd_wdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     halted,
    output logic                     overflow
);

    localparam int              C_AW   = $clog2(DEPTH);
    localparam int              C_CW   = C_AW + 1;
    localparam logic [C_CW-1:0] C_FULL = C_CW'(DEPTH);
    localparam bit              C_CIRC = (MODE == 1);

    typedef enum logic [0:0] {
        ST_ARMED  = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t             r_state;
    logic [C_AW-1:0]    r_wr_ptr;
    logic [C_AW-1:0]    r_rd_ptr;
    logic [C_CW-1:0]    r_count;
    logic               r_overflow;
    logic [3*XLEN-1:0]  r_mem [DEPTH];

    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_write;
    logic               w_acc;
    logic               w_adv_rd;
    logic               w_stop_hit;
    logic [3*XLEN-1:0]  w_head;

    assign w_full     = (r_count == C_FULL);
    assign rd_valid   = (r_count != '0);
    assign w_pop      = rd_valid && rd_ready;
    assign w_push     = trc_valid && (r_state == ST_ARMED);
    // A push into a full buffer with no pop is lost (stop-when-full) or
    // replaces the oldest entry (circular); either way it is an overflow.
    assign w_drop     = w_push && w_full && !w_pop;
    assign w_write    = w_push && (!w_full || w_pop || C_CIRC);
    assign w_acc      = w_push && !w_drop;
    assign w_adv_rd   = w_pop || (C_CIRC && w_drop);
    assign w_stop_hit = trc_valid && stop_en && (trc_pc == stop_pc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_ARMED;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_state    <= ST_ARMED;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + C_AW'(1);
            end
            if (w_adv_rd) begin
                r_rd_ptr <= r_rd_ptr + C_AW'(1);
            end
            r_count <= r_count + C_CW'(w_acc) - C_CW'(w_pop);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                ST_ARMED:  if (w_stop_hit) r_state <= ST_HALTED;
                default:   r_state <= ST_HALTED;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (w_write && !clear) begin
            r_mem[r_wr_ptr] <= {trc_pc, trc_iaddr, trc_wdata};
        end
    end

    assign w_head   = r_mem[r_rd_ptr];
    assign rd_pc    = w_head[3*XLEN-1 -: XLEN];
    assign rd_iaddr = w_head[2*XLEN-1 -: XLEN];
    assign rd_wdata = w_head[XLEN-1:0];
    assign count    = r_count;
    assign halted   = (r_state == ST_HALTED);
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_cpu_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_trace_buffer
// Brief    : Directed bench driving a stop-when-full and a circular instance
//            (DEPTH 4) from shared stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_trace_buffer;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            clear;
    logic            trc_valid;
    logic [XLEN-1:0] trc_pc;
    logic [XLEN-1:0] trc_iaddr;
    logic [XLEN-1:0] trc_wdata;
    logic            stop_en;
    logic [XLEN-1:0] stop_pc;
    logic            rd_ready;

    logic            rd_valid0, rd_valid1;
    logic [XLEN-1:0] rd_pc0, rd_pc1, rd_iaddr0, rd_iaddr1, rd_wdata0, rd_wdata1;
    logic [2:0]      count0, count1;
    logic            halted0, halted1, overflow0, overflow1;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cpu_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .MODE(0)) u_dut0 (
        .clk(clk), .reset(reset), .clear(clear),
        .trc_valid(trc_valid), .trc_pc(trc_pc), .trc_iaddr(trc_iaddr), .trc_wdata(trc_wdata),
        .stop_en(stop_en), .stop_pc(stop_pc), .rd_ready(rd_ready),
        .rd_valid(rd_valid0), .rd_pc(rd_pc0), .rd_iaddr(rd_iaddr0), .rd_wdata(rd_wdata0),
        .count(count0), .halted(halted0), .overflow(overflow0)
    );

    cpu_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .MODE(1)) u_dut1 (
        .clk(clk), .reset(reset), .clear(clear),
        .trc_valid(trc_valid), .trc_pc(trc_pc), .trc_iaddr(trc_iaddr), .trc_wdata(trc_wdata),
        .stop_en(stop_en), .stop_pc(stop_pc), .rd_ready(rd_ready),
        .rd_valid(rd_valid1), .rd_pc(rd_pc1), .rd_iaddr(rd_iaddr1), .rd_wdata(rd_wdata1),
        .count(count1), .halted(halted1), .overflow(overflow1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One sample per cycle; iaddr and wdata are derived from pc so they can be checked too.
    task automatic push(input logic [31:0] pc);
        trc_valid = 1'b1;
        trc_pc    = pc;
        trc_iaddr = pc + 32'h1000;
        trc_wdata = ~pc;
        step();
        trc_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; trc_valid = 1'b0; trc_pc = '0; trc_iaddr = '0;
        trc_wdata = '0; stop_en = 1'b0; stop_pc = '0; rd_ready = 1'b0;
        step();
        step();
        chk("rst_count", {29'd0, count0}, 32'd0);
        chk("rst_valid", {31'd0, rd_valid0}, 32'd0);
        chk("rst_halted", {30'd0, halted1, halted0}, 32'd0);
        chk("rst_ovf", {30'd0, overflow1, overflow0}, 32'd0);
        reset = 1'b0;

        // Mid-stream asynchronous reset
        push(32'h100); push(32'h104); push(32'h108);
        chk("t1_count3", {29'd0, count0}, 32'd3);
        #2 reset = 1'b1;
        #1;
        chk("t1_async_count", {26'd0, count1, count0}, 32'd0);
        chk("t1_async_valid", {30'd0, rd_valid1, rd_valid0}, 32'd0);
        #1 reset = 1'b0;
        push(32'h200);
        chk("t1_post_count", {29'd0, count0}, 32'd1);
        chk("t1_post_pc", rd_pc0, 32'h200);
        do_clear();
        chk("t1_clear_count", {26'd0, count1, count0}, 32'd0);

        // Basic capture and show-ahead drain
        push(32'h0); push(32'h4); push(32'h8);
        chk("t2_count0", {29'd0, count0}, 32'd3);
        chk("t2_count1", {29'd0, count1}, 32'd3);
        chk("t2_iaddr", rd_iaddr0, 32'h1000);
        chk("t2_wdata", rd_wdata1, 32'hFFFF_FFFF);
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t2_drain_pc", rd_pc0, 32'(i * 4));
            step();
        end
        rd_ready = 1'b0;
        chk("t2_empty_count", {29'd0, count0}, 32'd0);
        chk("t2_empty_valid", {31'd0, rd_valid0}, 32'd0);

        // Overflow: drop in MODE 0, overwrite in MODE 1
        do_clear();
        for (int i = 0; i < 6; i++) push(32'(i * 4));
        chk("t3_count0", {29'd0, count0}, 32'd4);
        chk("t4_count1", {29'd0, count1}, 32'd4);
        chk("t3_ovf0", {31'd0, overflow0}, 32'd1);
        chk("t4_ovf1", {31'd0, overflow1}, 32'd1);
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_drain_m0", rd_pc0, 32'(i * 4));
            chk("t4_drain_m1", rd_pc1, 32'(8 + i * 4));
            step();
        end
        rd_ready = 1'b0;
        chk("t3_drained", {26'd0, count1, count0}, 32'd0);
        chk("t3_ovf_sticky", {31'd0, overflow0}, 32'd1);
        do_clear();
        chk("t3_ovf_cleared", {30'd0, overflow1, overflow0}, 32'd0);

        // Stop-PC freeze
        stop_en = 1'b1; stop_pc = 32'h10;
        push(32'h08); push(32'h0C);
        chk("t5_not_halted", {31'd0, halted0}, 32'd0);
        push(32'h10);
        chk("t5_halted", {30'd0, halted1, halted0}, 32'h3);
        stop_pc = 32'h14;
        push(32'h14);
        chk("t5_count", {29'd0, count0}, 32'd3);
        chk("t5_head", rd_pc0, 32'h08);
        do_clear();
        stop_en = 1'b0;
        chk("t5_clr_count", {29'd0, count0}, 32'd0);
        chk("t5_clr_halted", {30'd0, halted1, halted0}, 32'd0);

        // Push while empty with rd_ready high
        rd_ready = 1'b1;
        push(32'h40);
        rd_ready = 1'b0;
        chk("t6_empty_pushpop", {29'd0, count0}, 32'd1);
        do_clear();

        // Full with simultaneous push and pop, then clear with push
        for (int i = 0; i < 4; i++) push(32'(i * 4));
        rd_ready = 1'b1;
        chk("t6_head_before", rd_pc1, 32'h0);
        push(32'h10);
        rd_ready = 1'b0;
        chk("t6_count0", {29'd0, count0}, 32'd4);
        chk("t6_count1", {29'd0, count1}, 32'd4);
        chk("t6_ovf", {30'd0, overflow1, overflow0}, 32'd0);
        chk("t6_head_after", rd_pc0, 32'h4);
        clear = 1'b1;
        push(32'h14);
        clear = 1'b0;
        chk("t6_clr_count", {26'd0, count1, count0}, 32'd0);
        chk("t6_clr_valid", {30'd0, rd_valid1, rd_valid0}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
